// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ==== if_fetch_unit_pkg : fetch-stage default constants and fetch FSM encoding (rev 1.0) ====
package if_fetch_unit_pkg;

   localparam int unsigned XLEN_DEF      = 64;
   localparam int unsigned ILEN_DEF      = 32;
   localparam logic [63:0] RESET_PC_DEF  = 64'h8000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_skid_buf.sv
`default_nettype none
// ==== if_skid_buf : one-entry {pc, instr} holding register for a stalled decode (rev 1.0) ====
module if_skid_buf #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned ILEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [ILEN-1:0] instr_i,
   output logic [XLEN-1:0] pc_o,
   output logic [ILEN-1:0] instr_o,
   output logic            full_o
);

   logic [XLEN-1:0] pc_q;
   logic [ILEN-1:0] instr_q;
   logic            full_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= '0;
         instr_q <= '0;
         full_q  <= 1'b0;
      end else if (clear_i) begin
         full_q  <= 1'b0;
      end else if (load_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
         full_q  <= 1'b1;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign full_o  = full_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ==== if_fetch_unit : fetch PC, single-outstanding imem request FSM, IF/ID register (rev 1.0) ====
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned          XLEN      = XLEN_DEF,
   parameter int unsigned          ILEN      = ILEN_DEF,
   parameter logic [XLEN-1:0]      RESET_PC  = XLEN'(RESET_PC_DEF),
   parameter logic [ILEN-1:0]      NOP_INSTR = ILEN'(NOP_INSTR_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stalln_pc,
   input  logic            stalln_id,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] pc_o,
   output logic [ILEN-1:0] instr_o,
   output logic            id_valid_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
   logic            ifid_valid_q, ifid_valid_d;

   logic            buf_load, buf_clear, buf_full;
   logic [XLEN-1:0] buf_pc;
   logic [ILEN-1:0] buf_instr;
   logic            adv;

   assign adv = stalln_pc & stalln_id;

   if_skid_buf #(.XLEN(XLEN), .ILEN(ILEN)) u_skid_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .pc_i    (pc_q),
      .instr_i (imem_rsp_data),
      .pc_o    (buf_pc),
      .instr_o (buf_instr),
      .full_o  (buf_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         drop_q       <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_q       <= drop_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_d       = drop_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;

      if (redirect_valid) begin
         // The old request may still be in flight; drop marks its response as stale.
         pc_d         = redirect_pc & ~XLEN'(3);
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
         buf_clear    = 1'b1;
         if (state_q == S_WAIT && !imem_rsp_valid) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
         end else begin
            drop_d  = 1'b0;
            state_d = S_REQ;
         end
      end else begin
         if (stalln_id) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
         end
         unique case (state_q)
            S_REQ: begin
               if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else if (adv) begin
                     ifid_pc_d    = pc_q;
                     ifid_instr_d = imem_rsp_data;
                     ifid_valid_d = 1'b1;
                     pc_d         = pc_q + XLEN'(4);
                     state_d      = S_REQ;
                  end else begin
                     buf_load = 1'b1;
                     state_d  = S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (adv && buf_full) begin
                  ifid_pc_d    = buf_pc;
                  ifid_instr_d = buf_instr;
                  ifid_valid_d = 1'b1;
                  pc_d         = pc_q + XLEN'(4);
                  buf_clear    = 1'b1;
                  state_d      = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   assign imem_req_valid = (state_q == S_REQ) && rst_n;
   assign imem_req_addr  = pc_q;
   assign pc_o           = ifid_pc_q;
   assign instr_o        = ifid_instr_q;
   assign id_valid_o     = ifid_valid_q;

endmodule
`default_nettype wire
